fixed_point_addsub_pipe: RTL
============================

FIXED_POINT_ADDSUB_PIPE -- requirements
Module: fixed_point_addsub_pipe

Interface
REQ-001 SHALL have parameter N, default 32: data path width in bits.
REQ-002 SHALL have parameter STAGES, default 4: pipeline depth, 1..8; N % STAGES SHALL be 0, checked at elaboration.
REQ-003 SHALL have parameter SATURATE, default 0: 1 clamps signed overflow results.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port in_valid  input  1  operand beat present.
REQ-007 SHALL have port in_ready  output  1  block accepts the beat this cycle.
REQ-008 SHALL have port a  input  N  minuend/augend, two's complement.
REQ-009 SHALL have port b  input  N  subtrahend/addend, two's complement.
REQ-010 SHALL have port op  input  1  0 = add, 1 = subtract.
REQ-011 SHALL have port carry_in  input  1  carry-in (add) or borrow-in (subtract).
REQ-012 SHALL have port out_valid  output  1  result beat present.
REQ-013 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-014 SHALL have port c  output  N  result.
REQ-015 SHALL have port carry_out  output  1  unsigned carry (add) or borrow (subtract).
REQ-016 SHALL have port overflow  output  1  signed overflow, pre-saturation.

Function
REQ-017 Add SHALL compute {carry_out,c} = a + b + carry_in, unsigned N+1 bit.
REQ-018 Subtract SHALL compute c = a - b - carry_in, via a + ~b + !carry_in; carry_out = 1 when a < b + carry_in unsigned (borrow out).
REQ-019 overflow SHALL be 1 when the operand sign bits, with b inverted for subtract, agree and differ from the raw result sign bit.
REQ-020 With SATURATE=1 and overflow=1, c SHALL be {0,1...1} when the effective operand sign is 0, {1,0...0} when it is 1; carry_out is unaffected.
REQ-021 Carry chain SHALL be split into STAGES segments of W=N/STAGES bits; stage k adds segment k with the registered carry from stage k-1.
REQ-022 Upper operand segments SHALL be delayed by skew registers; lower result segments SHALL be delayed by deskew registers so that c is aligned at the output.
REQ-023 Latency SHALL be exactly STAGES cycles from accepted input to out_valid, absent stalls; throughput one beat per cycle.
REQ-024 Pipeline SHALL advance when adv = out_ready | ~out_valid; in_ready SHALL equal adv (combinational, no dependency on in_valid).
REQ-025 When adv = 0, every stage register, including c, carry_out and overflow, SHALL hold its value.
REQ-026 A beat SHALL be accepted only when in_valid & in_ready; stage-0 valid SHALL load in_valid & adv.
REQ-027 Output payload SHALL remain stable while out_valid = 1 and out_ready = 0.
REQ-028 Bubbles SHALL propagate as invalid stages; no beat SHALL be duplicated or dropped.
REQ-029 With STAGES=1, the block SHALL be a single registered adder with a latency of 1.

Reset
REQ-030 On rst_n low, all valid bits SHALL clear asynchronously; out_valid, c, carry_out and overflow SHALL be 0.
REQ-031 In-flight beats SHALL be discarded on reset mid-operation; the first beat accepted after release SHALL emerge STAGES cycles later.
REQ-032 in_ready SHALL be 1 during and immediately after reset, because out_valid = 0.

Structure
REQ-033 A shared package fixed_point_pkg SHALL hold the op typedef (OP_ADD=1'b0, OP_SUB=1'b1) and a max/min saturation constant function of N.
REQ-034 One sub-module, fixed_point_add_segment, SHALL be used: a registered W-bit adder with carry in/out and an enable; it SHALL be instantiated STAGES times by generate.

Verification (N=16, STAGES=4 unless stated)
REQ-035 Add 16'h7FFF + 16'h0001, carry_in=0 -> after 4 cycles c=16'h8000, carry_out=0, overflow=1; with SATURATE=1, c=16'h7FFF.
REQ-036 Sub 16'h0003 - 16'h0005, carry_in=1 -> c=16'hFFFD, carry_out=1, overflow=0.
REQ-037 Carry ripple across all segments: 16'hFFFF + 16'h0000, carry_in=1 -> c=16'h0000, carry_out=1.
REQ-038 Back-to-back 8 beats; out_ready low for 3 cycles mid-stream -> in_ready low for the same cycles; all 8 results in order, none lost, c stable while stalled.
REQ-039 Assert rst_n low with 3 beats in flight -> out_valid=0 immediately; after release, a single new beat appears after exactly 4 cycles.
REQ-040 Random add/sub for N in {8,32} and STAGES in {1,2,4}, against an N+1-bit reference model -> c, carry_out and overflow match on every beat.

Source files
------------

// File: rtl/fixed_point_pkg.sv
// Shared definitions for the pipelined fixed-point adder/subtractor:
// operation encoding, per-beat sign tag and saturation limits.
package fixed_point_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    // Operand signs travel with each beat so overflow can be judged at the output.
    typedef struct packed {
        logic a_sgn;
        logic b_sgn;
        logic sub;
    } sign_tag_t;

    function automatic logic [63:0] sat_max_f(input int unsigned n);
        return (64'd1 << (n - 32'd1)) - 64'd1;
    endfunction

    function automatic logic [63:0] sat_min_f(input int unsigned n);
        return 64'd1 << (n - 32'd1);
    endfunction

endpackage

// File: rtl/fixed_point_add_segment.sv
// One W-bit slice of the carry chain: registered sum and carry, held
// whenever the pipeline is not advancing.
module fixed_point_add_segment
    import fixed_point_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);

    logic [W-1:0] sum_d, sum_q;
    logic         cout_d, cout_q;

    // Next slice result, or hold while stalled.
    always_comb begin
        sum_d  = sum_q;
        cout_d = cout_q;
        if (en) begin
            {cout_d, sum_d} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        end else begin
            sum_d  = sum_q;
            cout_d = cout_q;
        end
    end

    // Slice state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else begin
            sum_q  <= sum_d;
            cout_q <= cout_d;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: rtl/fixed_point_addsub_pipe.sv
// Pipelined two's complement add/subtract: the carry chain is cut into
// STAGES registered slices with operand skew and result deskew.
module fixed_point_addsub_pipe
    import fixed_point_pkg::*;
#(
    parameter int N        = 32,
    parameter int STAGES   = 4,
    parameter int SATURATE = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         op,
    input  logic         carry_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] c,
    output logic         carry_out,
    output logic         overflow
);

    localparam int W = N / STAGES;
    localparam logic [63:0] SAT_MAX_W = sat_max_f(N);
    localparam logic [63:0] SAT_MIN_W = sat_min_f(N);
    localparam logic [N-1:0] SAT_MAX = SAT_MAX_W[N-1:0];
    localparam logic [N-1:0] SAT_MIN = SAT_MIN_W[N-1:0];

    if ((STAGES < 1) || (STAGES > 8) || ((N % STAGES) != 0)) begin : g_param_check
        $error("fixed_point_addsub_pipe: STAGES must be 1..8 and divide N");
    end

    logic              adv_s;
    logic [N-1:0]      b_eff_s;
    logic              cin_eff_s;
    logic [STAGES-1:0] vld_d, vld_q;
    sign_tag_t         sgn_d [STAGES];
    sign_tag_t         sgn_q [STAGES];
    logic [W-1:0]      seg_sum_s [STAGES];
    logic [STAGES-1:0] seg_cout_s;
    logic [N-1:0]      c_raw_s;
    sign_tag_t         tag_s;
    logic              ovf_s;

    // Subtract is folded into an add of ~b with an inverted carry-in.
    always_comb begin
        adv_s     = out_ready | ~vld_q[STAGES-1];
        b_eff_s   = (op == OP_SUB) ? ~b : b;
        cin_eff_s = (op == OP_SUB) ? ~carry_in : carry_in;
    end

    // Valid bits and sign tags shift with the data.
    always_comb begin
        vld_d = vld_q;
        sgn_d = sgn_q;
        if (adv_s) begin
            vld_d[0] = in_valid;
            sgn_d[0] = '{a_sgn: a[N-1], b_sgn: b_eff_s[N-1], sub: op};
            for (int i = 1; i < STAGES; i++) begin
                vld_d[i] = vld_q[i-1];
                sgn_d[i] = sgn_q[i-1];
            end
        end else begin
            vld_d = vld_q;
            sgn_d = sgn_q;
        end
    end

    // Valid and tag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int i = 0; i < STAGES; i++) begin
                sgn_q[i] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            sgn_q <= sgn_d;
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_seg
        localparam int D = STAGES - 1 - k;
        logic [W-1:0] a_in_s, b_in_s;
        logic         cin_in_s;

        if (k == 0) begin : g_head
            assign a_in_s   = a[W-1:0];
            assign b_in_s   = b_eff_s[W-1:0];
            assign cin_in_s = cin_eff_s;
        end else begin : g_skew
            logic [W-1:0] a_sk_d [k];
            logic [W-1:0] a_sk_q [k];
            logic [W-1:0] b_sk_d [k];
            logic [W-1:0] b_sk_q [k];

            // Slice k waits k cycles for the carry from below.
            always_comb begin
                a_sk_d = a_sk_q;
                b_sk_d = b_sk_q;
                if (adv_s) begin
                    a_sk_d[0] = a[k*W +: W];
                    b_sk_d[0] = b_eff_s[k*W +: W];
                    for (int i = 1; i < k; i++) begin
                        a_sk_d[i] = a_sk_q[i-1];
                        b_sk_d[i] = b_sk_q[i-1];
                    end
                end else begin
                    a_sk_d = a_sk_q;
                    b_sk_d = b_sk_q;
                end
            end

            // Operand skew registers.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < k; i++) begin
                        a_sk_q[i] <= '0;
                        b_sk_q[i] <= '0;
                    end
                end else begin
                    a_sk_q <= a_sk_d;
                    b_sk_q <= b_sk_d;
                end
            end

            assign a_in_s   = a_sk_q[k-1];
            assign b_in_s   = b_sk_q[k-1];
            assign cin_in_s = seg_cout_s[k-1];
        end

        fixed_point_add_segment #(.W(W)) u_add (
            .clk  (clk),
            .rst_n(rst_n),
            .en   (adv_s),
            .a    (a_in_s),
            .b    (b_in_s),
            .cin  (cin_in_s),
            .sum  (seg_sum_s[k]),
            .cout (seg_cout_s[k])
        );

        if (D == 0) begin : g_direct
            assign c_raw_s[k*W +: W] = seg_sum_s[k];
        end else begin : g_deskew
            logic [W-1:0] ds_d [D];
            logic [W-1:0] ds_q [D];

            // Lower slices finish early and are delayed to line up with the top.
            always_comb begin
                ds_d = ds_q;
                if (adv_s) begin
                    ds_d[0] = seg_sum_s[k];
                    for (int i = 1; i < D; i++) begin
                        ds_d[i] = ds_q[i-1];
                    end
                end else begin
                    ds_d = ds_q;
                end
            end

            // Result deskew registers.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < D; i++) begin
                        ds_q[i] <= '0;
                    end
                end else begin
                    ds_q <= ds_d;
                end
            end

            assign c_raw_s[k*W +: W] = ds_q[D-1];
        end
    end

    assign tag_s = sgn_q[STAGES-1];

    // Output decode: overflow from operand signs, optional clamp, borrow polarity.
    always_comb begin
        ovf_s = (tag_s.a_sgn == tag_s.b_sgn) && (c_raw_s[N-1] != tag_s.a_sgn);
        if ((SATURATE != 0) && ovf_s) begin
            c = tag_s.a_sgn ? SAT_MIN : SAT_MAX;
        end else begin
            c = c_raw_s;
        end
        carry_out = tag_s.sub ? ~seg_cout_s[STAGES-1] : seg_cout_s[STAGES-1];
        overflow  = ovf_s;
        out_valid = vld_q[STAGES-1];
        in_ready  = adv_s;
    end

endmodule
